adxl355_drdy_multi: RTL
=======================

# adxl355_drdy_multi

Multi-channel successor to the single-channel ADXL355 sync/drdy generator. It takes the 1 kHz single-cycle sync pulse in the 40 MHz system domain and produces, per accelerometer channel, a width-extended hardware sync and a delayed single-cycle drdy strobe. Width and delay are runtime-programmable per channel. It also flags drdy overruns and loss of the incoming sync. It sits between the 1 kHz sync source and the per-sensor SPI readers.

## Interface
Parameters:
- CLK_HZ, 40000000, i_clk frequency in Hz.
- CHANNELS, 2, number of sensor channels (1..8).
- TIMING_BITS, 18, width of the per-channel width and delay counters and config registers.
- SYNC_WIDTH_US, 20, reset value of every channel's width register, converted to cycles (20 µs → 800).
- DRDY_DELAY_US, 50, reset value of every channel's delay register, converted to cycles (50 µs → 2000).
- TIMEOUT_US, 2000, sync-loss timeout, converted to cycles (2000 µs → 80000).

Ports:
- i_clk  in  1  system clock, 40 MHz.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_clk_sync  in  1  1 kHz sync, one i_clk cycle wide.
- i_cfg_we  in  1  config write strobe.
- i_cfg_ch  in  max(1,$clog2(CHANNELS))  target channel for the config write.
- i_cfg_sel  in  1  0 = width register, 1 = delay register.
- i_cfg_data  in  TIMING_BITS  value to write, in i_clk cycles.
- i_overrun_clr  in  1  clears all overrun flags.
- o_clk_sync  out  CHANNELS  extended sync pulse, one bit per channel.
- o_clk_drdy  out  CHANNELS  one-cycle drdy strobe, one bit per channel.
- o_overrun  out  CHANNELS  sticky overrun flag, one bit per channel.
- o_sync_lost  out  1  no sync seen within the timeout.
- o_sync_cnt  out  16  count of received syncs, wraps.

## Operation
- Cycle conversion: us·CLK_HZ/1e6 is evaluated at elaboration as an integer and truncated. Elaboration fails if any converted value does not fit its counter.
- Each channel holds W (width) and D (delay) registers, plus a staged copy of each.
- A config write updates only the staged copy; it has no effect on counters already running.
- i_clk_sync latches every channel's staged copy into W and D.
  - A write in the same cycle as i_clk_sync is latched by that same sync.
  - A write with i_cfg_ch ≥ CHANNELS is ignored.
- Sync pulse:
  - On i_clk_sync the width counter loads W.
  - o_clk_sync stays high while the counter is nonzero; the counter decrements each cycle.
  - A retrigger while high reloads the counter, extending the pulse.
  - W = 0 produces no pulse.
- drdy pulse:
  - On i_clk_sync the delay counter loads D and the channel becomes pending.
  - o_clk_drdy fires for one cycle when the pending count expires, then pending clears.
- Overrun:
  - i_clk_sync arriving while a channel is still pending sets that channel's o_overrun.
  - The pending drdy is dropped and the counter restarts from the new D.
  - If set and i_overrun_clr occur in the same cycle, set wins.
- Sync loss:
  - A cycle counter clears on each i_clk_sync and otherwise increments, saturating at the timeout.
  - o_sync_lost goes 1 when the counter reaches the timeout value and returns to 0 on the cycle after the next sync.
- o_sync_cnt increments on every i_clk_sync, including back-to-back ones, and wraps FFFF→0000.

## Timing
Sync sampled high at edge t:
- o_clk_sync is high over cycles t+1 .. t+W.
- o_clk_drdy is high only at cycle t+1+D; D = 0 gives drdy at t+1.
- o_overrun and o_sync_cnt update at t+1.
- o_sync_lost is high from cycle t+1+TIMEOUT_CYCLES when no further sync arrives.

All outputs are registered.

Reset values:
- o_clk_sync = 0, o_clk_drdy = 0, o_overrun = 0, o_sync_lost = 0, o_sync_cnt = 0.
- All counters idle (not pending).
- W and D registers and their staged copies take the parameter defaults.
- The timeout counter is 0.

Reset asserted mid-pulse drops output pulses and pending drdys immediately; nothing is emitted after release until the next sync.

## Structure
- Shared package adxl355_pkg:
  - us-to-cycles constant function.
  - Config select encodings CFG_WIDTH = 0 and CFG_DELAY = 1.
- Sub-module adxl355_drdy_chan, instantiated CHANNELS times:
  - Holds the staged and live W/D registers, the width and delay counters, pending state and overrun flag.
- The top level holds:
  - Config decode.
  - The timeout counter.
  - o_sync_cnt.

## Test plan
- Reset, then a single sync at t with defaults → o_clk_sync high t+1..t+800 on all channels; o_clk_drdy only at t+2001; o_sync_cnt = 1.
- Write ch1 D=10 and W=0, then sync; on the following sync → ch1: drdy at t+11 and no sync pulse; ch0 unchanged.
- Two syncs 1000 cycles apart with D=2000 → overrun[0] = 1; a single drdy at second_sync+2001; i_overrun_clr clears the flag; clr coincident with a new overrun leaves it at 1.
- Retrigger 500 cycles into the width pulse → o_clk_sync continuous from t+1 to t+500+800.
- No sync for 80000 cycles after the last one → o_sync_lost = 1 at last+80001; the next sync clears it one cycle later; 65536 syncs wrap o_sync_cnt to 0.
- Assert i_rstn low in the middle of a pending drdy → no drdy fires, all outputs 0, registers back to 800/2000.

Source files
------------

// File: rtl/adxl355_pkg.sv
// Shared constants for the ADXL355 sync/drdy generator: config select codes
// and the microsecond-to-cycle conversion used at elaboration.
package adxl355_pkg;

   typedef enum logic {
      CFG_WIDTH = 1'b0,
      CFG_DELAY = 1'b1
   } cfg_sel_e;

   function automatic longint unsigned us_to_cycles(input longint unsigned us,
                                                    input longint unsigned clk_hz);
      return (us * clk_hz) / 64'd1000000;
   endfunction

endpackage

// File: rtl/adxl355_drdy_chan.sv
// One sensor channel: staged/live width and delay registers, width and delay
// down-counters, pending drdy state and sticky overrun flag.
module adxl355_drdy_chan
   import adxl355_pkg::*;
#(
   parameter int                     TIMING_BITS = 18,
   parameter logic [TIMING_BITS-1:0] W_RST       = '0,
   parameter logic [TIMING_BITS-1:0] D_RST       = '0
) (
   input  logic                   i_clk,
   input  logic                   i_rstn,
   input  logic                   i_sync,
   input  logic                   i_we,
   input  logic                   i_sel,
   input  logic [TIMING_BITS-1:0] i_data,
   input  logic                   i_overrun_clr,
   output logic                   o_sync,
   output logic                   o_drdy,
   output logic                   o_overrun
);

   localparam logic [TIMING_BITS-1:0] ONE = TIMING_BITS'(1);

   logic [TIMING_BITS-1:0] w_stg, d_stg, w_live, d_live, w_cnt, d_cnt;
   logic [TIMING_BITS-1:0] w_stg_nxt, d_stg_nxt;
   logic                   pend;

   // A write coincident with a sync must reach the live registers on that sync.
   always_comb begin
      w_stg_nxt = w_stg;
      d_stg_nxt = d_stg;
      if (i_we && i_sel == CFG_WIDTH) w_stg_nxt = i_data;
      if (i_we && i_sel == CFG_DELAY) d_stg_nxt = i_data;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         w_stg     <= W_RST;
         d_stg     <= D_RST;
         w_live    <= W_RST;
         d_live    <= D_RST;
         w_cnt     <= '0;
         d_cnt     <= '0;
         pend      <= 1'b0;
         o_sync    <= 1'b0;
         o_drdy    <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         w_stg <= w_stg_nxt;
         d_stg <= d_stg_nxt;
         if (i_sync) begin
            // counters start from the values live before this sync latches
            w_live <= w_stg_nxt;
            d_live <= d_stg_nxt;
            w_cnt  <= w_live;
            o_sync <= (w_live != '0);
            d_cnt  <= d_live;
            pend   <= (d_live != '0);
            o_drdy <= (d_live == '0);
            if (pend)               o_overrun <= 1'b1;
            else if (i_overrun_clr) o_overrun <= 1'b0;
         end else begin
            w_cnt  <= (w_cnt != '0) ? w_cnt - ONE : '0;
            o_sync <= (w_cnt > ONE);
            o_drdy <= pend && (d_cnt == ONE);
            if (pend) begin
               d_cnt <= d_cnt - ONE;
               if (d_cnt == ONE) pend <= 1'b0;
            end
            if (i_overrun_clr) o_overrun <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/adxl355_drdy_multi.sv
// Multi-channel ADXL355 sync/drdy generator: config decode, per-channel
// generators, sync-loss timeout and received-sync counter.
module adxl355_drdy_multi
   import adxl355_pkg::*;
#(
   parameter int unsigned CLK_HZ        = 40000000,
   parameter int unsigned CHANNELS      = 2,
   parameter int unsigned TIMING_BITS   = 18,
   parameter int unsigned SYNC_WIDTH_US = 20,
   parameter int unsigned DRDY_DELAY_US = 50,
   parameter int unsigned TIMEOUT_US    = 2000,
   localparam int         CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                   i_clk,
   input  logic                   i_rstn,
   input  logic                   i_clk_sync,
   input  logic                   i_cfg_we,
   input  logic [CH_W-1:0]        i_cfg_ch,
   input  logic                   i_cfg_sel,
   input  logic [TIMING_BITS-1:0] i_cfg_data,
   input  logic                   i_overrun_clr,
   output logic [CHANNELS-1:0]    o_clk_sync,
   output logic [CHANNELS-1:0]    o_clk_drdy,
   output logic [CHANNELS-1:0]    o_overrun,
   output logic                   o_sync_lost,
   output logic [15:0]            o_sync_cnt
);

   localparam longint unsigned SYNC_CYC    = us_to_cycles(SYNC_WIDTH_US, CLK_HZ);
   localparam longint unsigned DELAY_CYC   = us_to_cycles(DRDY_DELAY_US, CLK_HZ);
   localparam longint unsigned TIMEOUT_CYC = us_to_cycles(TIMEOUT_US, CLK_HZ);
   localparam longint unsigned T_LIMIT     = 64'd1 << TIMING_BITS;
   localparam int              TO_W        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

   localparam logic [TIMING_BITS-1:0] W_RST  = TIMING_BITS'(SYNC_CYC);
   localparam logic [TIMING_BITS-1:0] D_RST  = TIMING_BITS'(DELAY_CYC);
   localparam logic [TO_W-1:0]        TO_MAX = TO_W'(TIMEOUT_CYC);

   if (SYNC_CYC >= T_LIMIT || DELAY_CYC >= T_LIMIT) begin : g_bad_timing
      $error("default width/delay does not fit TIMING_BITS");
   end
   if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
      $error("CHANNELS must be 1..8");
   end

   logic [CHANNELS-1:0] chan_we;
   logic [TO_W-1:0]     to_cnt, to_nxt;

   // Channel numbers at or above CHANNELS match no instance and are dropped.
   always_comb begin
      chan_we = '0;
      for (int c = 0; c < int'(CHANNELS); c++)
         if (i_cfg_we && i_cfg_ch == CH_W'(c)) chan_we[c] = 1'b1;
   end

   for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_chan
      adxl355_drdy_chan #(
         .TIMING_BITS (TIMING_BITS),
         .W_RST       (W_RST),
         .D_RST       (D_RST)
      ) u_chan (
         .i_clk         (i_clk),
         .i_rstn        (i_rstn),
         .i_sync        (i_clk_sync),
         .i_we          (chan_we[c]),
         .i_sel         (i_cfg_sel),
         .i_data        (i_cfg_data),
         .i_overrun_clr (i_overrun_clr),
         .o_sync        (o_clk_sync[c]),
         .o_drdy        (o_clk_drdy[c]),
         .o_overrun     (o_overrun[c])
      );
   end

   always_comb begin
      to_nxt = to_cnt;
      if (i_clk_sync)            to_nxt = '0;
      else if (to_cnt != TO_MAX) to_nxt = to_cnt + TO_W'(1);
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         to_cnt      <= '0;
         o_sync_lost <= 1'b0;
         o_sync_cnt  <= '0;
      end else begin
         to_cnt      <= to_nxt;
         o_sync_lost <= (to_nxt == TO_MAX);
         if (i_clk_sync) o_sync_cnt <= o_sync_cnt + 16'd1;
      end
   end

endmodule
